// File: rtl/scan_chain_ctrl.sv
// Scan sequencer: shift a word into the chain, run N capture cycles, shift it back out (recirculating).
// Latency 2*LEN+in_cycles cycles accept-to-out_valid; one command in flight, out_valid held until out_ready.
module scan_chain_ctrl #(
  parameter int LEN   = 8,
  parameter int CYC_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [LEN-1:0]   in_data,
  input  logic [CYC_W-1:0] in_cycles,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             SCE,
  output logic             SCD,
  input  logic             SO,
  output logic [LEN-1:0]   out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(LEN);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(LEN - 1);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, RUN, SHIFT_OUT, DONE} state_t;

  state_t           state;
  logic [LEN-1:0]   load_sr;
  logic [LEN-1:0]   out_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [CYC_W-1:0] run_cnt;
  logic             so_sel;

  // load_sr fills with zeros as it shifts, so outside SHIFT_IN its MSB is 0.
  assign SCD  = so_sel ? SO : load_sr[LEN-1];
  assign busy = (state != IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      load_sr   <= '0;
      out_sr    <= '0;
      bit_cnt   <= '0;
      run_cnt   <= '0;
      so_sel    <= 1'b0;
      SCE       <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            load_sr  <= in_data;
            run_cnt  <= in_cycles;
            bit_cnt  <= '0;
            SCE      <= 1'b1;
            in_ready <= 1'b0;
            state    <= SHIFT_IN;
          end else begin
            in_ready <= 1'b1;
          end
        end
        SHIFT_IN: begin
          load_sr <= {load_sr[LEN-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (run_cnt != '0) begin
              SCE   <= 1'b0;
              state <= RUN;
            end else begin
              so_sel <= 1'b1;
              state  <= SHIFT_OUT;
            end
          end
        end
        RUN: begin
          run_cnt <= run_cnt - 1'b1;
          if (run_cnt == CYC_W'(1)) begin
            SCE    <= 1'b1;
            so_sel <= 1'b1;
            state  <= SHIFT_OUT;
          end
        end
        SHIFT_OUT: begin
          out_sr  <= {out_sr[LEN-2:0], SO};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt   <= '0;
            out_data  <= {out_sr[LEN-2:0], SO};
            out_valid <= 1'b1;
            SCE       <= 1'b0;
            so_sel    <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
